// File: rtl/snn_pkg.sv
// Shared definitions for the spiking-network event path.
//   N_SRC_DEF      : default number of spike sources
//   TS_WIDTH_DEF   : default timestamp width
//   FIFO_DEPTH_DEF : default event queue depth (power of two)
//   spike_evt_t    : event record {src, ts} at default sizing
//   idx_width()    : index width for n entries, never below 1 bit
package snn_pkg;

    localparam int unsigned N_SRC_DEF      = 4;
    localparam int unsigned TS_WIDTH_DEF   = 8;
    localparam int unsigned FIFO_DEPTH_DEF = 4;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int unsigned SRC_W_DEF = idx_width(N_SRC_DEF);

    typedef struct packed {
        logic [SRC_W_DEF-1:0]    src;
        logic [TS_WIDTH_DEF-1:0] ts;
    } spike_evt_t;

endpackage

// File: rtl/spike_event_fifo.sv
// Event queue between the spike arbiter and the consumer.
//   clk, rst_n : clock, asynchronous active-low reset
//   push       : write push_data (ignored when full)
//   push_data  : event record to enqueue
//   pop        : discard head entry (ignored when empty)
//   head_data  : oldest entry, forced to zero when empty
//   full/empty : occupancy status
module spike_event_fifo
    import snn_pkg::*;
#(
    parameter int unsigned DATA_W = $bits(spike_evt_t),
    parameter int unsigned DEPTH  = FIFO_DEPTH_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head_data,
    output logic              full,
    output logic              empty
);

    localparam int unsigned AW = idx_width(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       count;
    logic              push_ok;
    logic              pop_ok;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    // Storage is not reset; the zero mux keeps the head outputs clean
    // while nothing valid is queued.
    assign head_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/spike_event_scheduler.sv
// Captures per-neuron spikes with a timestamp, arbitrates them round-robin
// into an event queue for the STDP synapse update engine.
//   clk, rst_n : clock, asynchronous active-low reset
//   en         : global enable for capture, timestamp and arbitration
//   spike_in   : one spike bit per source
//   evt_valid / evt_ready / evt_src / evt_ts : head-of-queue handshake
//   pending    : captured spikes not yet queued
//   overflow   : sticky dropped-spike flag, cleared by ovf_clr
module spike_event_scheduler
    import snn_pkg::*;
#(
    parameter int unsigned N_SRC      = N_SRC_DEF,
    parameter int unsigned TS_WIDTH   = TS_WIDTH_DEF,
    parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         en,
    input  logic [N_SRC-1:0]             spike_in,
    output logic                         evt_valid,
    input  logic                         evt_ready,
    output logic [idx_width(N_SRC)-1:0]  evt_src,
    output logic [TS_WIDTH-1:0]          evt_ts,
    output logic [N_SRC-1:0]             pending,
    output logic                         overflow,
    input  logic                         ovf_clr
);

    localparam int unsigned SRC_W = idx_width(N_SRC);
    localparam int unsigned EVT_W = SRC_W + TS_WIDTH;

    logic [TS_WIDTH-1:0] ts;
    logic [TS_WIDTH-1:0] pend_ts [N_SRC];
    logic [SRC_W-1:0]    last_grant;

    logic                grant_valid;
    logic [SRC_W-1:0]    grant_idx;
    logic [N_SRC-1:0]    grant_vec;
    logic [N_SRC-1:0]    drop_vec;

    logic                fifo_full;
    logic                fifo_empty;
    logic                pop;
    logic [EVT_W-1:0]    head;

    // Round-robin search starting one past the last granted source.
    // Fullness alone gates the grant, so a same-cycle pop never opens a slot.
    always_comb begin : arbiter
        int unsigned      cand;
        logic [SRC_W-1:0] idx;
        cand        = 0;
        idx         = '0;
        grant_valid = 1'b0;
        grant_idx   = '0;
        if (en && !fifo_full) begin
            for (int unsigned k = 1; k <= N_SRC; k++) begin
                cand = (32'(last_grant) + k) % N_SRC;
                idx  = SRC_W'(cand);
                if (!grant_valid && pending[idx]) begin
                    grant_valid = 1'b1;
                    grant_idx   = idx;
                end
            end
        end
    end

    always_comb begin
        grant_vec = '0;
        if (grant_valid) begin
            grant_vec[grant_idx] = 1'b1;
        end
    end

    // A spike is dropped only if its source is still pending and is not
    // being granted this cycle; a granted source accepts a fresh spike.
    assign drop_vec = {N_SRC{en}} & spike_in & pending & ~grant_vec;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ts         <= '0;
            pending    <= '0;
            last_grant <= SRC_W'(N_SRC - 1);
            overflow   <= 1'b0;
            for (int unsigned i = 0; i < N_SRC; i++) begin
                pend_ts[i] <= '0;
            end
        end else begin
            if (en) begin
                ts <= ts + 1'b1;
                for (int unsigned i = 0; i < N_SRC; i++) begin
                    if (spike_in[i] && !drop_vec[i]) begin
                        pending[i] <= 1'b1;
                        pend_ts[i] <= ts;
                    end else if (grant_vec[i]) begin
                        pending[i] <= 1'b0;
                    end
                end
                if (grant_valid) begin
                    last_grant <= grant_idx;
                end
            end
            if (|drop_vec) begin
                overflow <= 1'b1;
            end else if (ovf_clr) begin
                overflow <= 1'b0;
            end
        end
    end

    spike_event_fifo #(
        .DATA_W (EVT_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (grant_valid),
        .push_data ({grant_idx, pend_ts[grant_idx]}),
        .pop       (pop),
        .head_data (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign evt_valid         = !fifo_empty;
    assign pop               = evt_valid && evt_ready;
    assign {evt_src, evt_ts} = head;

endmodule
